// File: rtl/uart_rx.sv
// 8N1 UART receiver with a free-running oversampling tick, a two-flop
// synchroniser on the rx pin, mid-bit start validation and mid-bit data
// sampling. Good bytes are delivered with a one-cycle rx_valid pulse. A low
// stop bit gives a one-cycle frame_err pulse and the byte is dropped.
module uart_rx #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  // Rounded clocks-per-tick, minus one so the counter compares against its last value
  localparam int TICK_LIMIT = (CLOCK_FREQ + BAUD_RATE * OVERSAMPLE / 2) /
                              (BAUD_RATE * OVERSAMPLE) - 1;
  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam logic [SC_W-1:0] SC_MID  = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [31:0]     tick_cnt;
  logic            tick;
  logic            sync_1;
  logic            rx_s;
  logic [SC_W-1:0] sc;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;
  logic            load_byte;
  logic            flag_err;

  assign tick = (tick_cnt == 32'(TICK_LIMIT));

  // Free-running oversample tick counter, wraps at TICK_LIMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= 32'd0;
    end else if (tick) begin
      tick_cnt <= 32'd0;
    end else begin
      tick_cnt <= tick_cnt + 32'd1;
    end
  end

  // Two-flop synchroniser; both flops reset to the idle (high) line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= rx;
      rx_s   <= sync_1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic; every transition is qualified by tick
  always_comb begin
    state_next = state_reg;
    if (tick) begin
      case (state_reg)
        S_IDLE:  if (!rx_s) state_next = S_START;
        S_START: if (sc == SC_MID) state_next = rx_s ? S_IDLE : S_DATA;
        S_DATA:  if (sc == SC_LAST && bit_idx == 3'd7) state_next = S_STOP;
        S_STOP:  if (sc == SC_LAST) state_next = rx_s ? S_IDLE : S_BREAK;
        S_BREAK: if (rx_s) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // FSM outputs: busy level and the stop-bit decisions that drive the pulses
  always_comb begin
    busy      = (state_reg != S_IDLE);
    load_byte = tick && (state_reg == S_STOP) && (sc == SC_LAST) && rx_s;
    flag_err  = tick && (state_reg == S_STOP) && (sc == SC_LAST) && !rx_s;
  end

  // Sample counter, bit index and shift register, advanced on tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc        <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else if (tick) begin
      case (state_reg)
        S_START: begin
          if (sc == SC_MID) begin
            sc      <= '0;
            bit_idx <= 3'd0;
          end else begin
            sc <= sc + 1'b1;
          end
        end
        S_DATA: begin
          if (sc == SC_LAST) begin
            sc                 <= '0;
            shift_reg[bit_idx] <= rx_s;
            bit_idx            <= bit_idx + 3'd1;
          end else begin
            sc <= sc + 1'b1;
          end
        end
        S_STOP: begin
          sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
        end
        default: begin
          sc <= '0;
        end
      endcase
    end
  end

  // Registered outputs: byte capture and the two mutually exclusive pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= load_byte;
      frame_err <= flag_err;
      if (load_byte) begin
        rx_data <= shift_reg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames,
// checked against a frame-level model (expected event queue per frame).
module tb_uart_rx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int OS       = 16;
  localparam int BIT_CLK  = 160;
  localparam int EV_ERR   = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int failures = 0;

  // Model: each frame queues either its byte (0..255) or a framing-error event
  int         exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         mon_exp;
  logic [1:0] mon_kind;

  always #5 clk = ~clk;

  uart_rx #(
    .CLOCK_FREQ(CLK_FREQ),
    .BAUD_RATE (BAUD),
    .OVERSAMPLE(OS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every output pulse cycle is matched against the next expected event
  always @(negedge clk) begin
    if (rst_n && (rx_valid || frame_err)) begin
      mon_exp = -1;
      if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
      if (mon_exp < 0)            mon_kind = 2'b00;
      else if (mon_exp == EV_ERR) mon_kind = 2'b10;
      else                        mon_kind = 2'b01;
      check_val("pulse_kind", {30'd0, frame_err, rx_valid}, {30'd0, mon_kind});
      if (mon_exp >= 0 && mon_exp < EV_ERR) begin
        check_val("rx_data", {24'd0, rx_data}, mon_exp);
        last_good = mon_exp[7:0];
      end else if (mon_exp == EV_ERR) begin
        check_val("data_hold", {24'd0, rx_data}, {24'd0, last_good});
      end
    end
  end

  task automatic bit_hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Drive one 8N1 frame; the matching event must appear before the stop bit ends
  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_q.push_back(stop ? int'(d) : EV_ERR);
    bit_hold(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) bit_hold(d[i], BIT_CLK);
    bit_hold(stop, BIT_CLK);
    check_val("frame_done", exp_q.size(), 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       stop;

    // 1: reset held while rx toggles
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx = 1'($urandom);
      repeat (7) @(negedge clk);
      check_val("rst_data",  {24'd0, rx_data}, 0);
      check_val("rst_valid", {31'd0, rx_valid}, 0);
      check_val("rst_ferr",  {31'd0, frame_err}, 0);
      check_val("rst_busy",  {31'd0, busy}, 0);
    end
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bit_hold(1'b1, 2 * BIT_CLK);

    // 2: single good frame
    send_frame(8'hA5, 1'b1);
    bit_hold(1'b1, BIT_CLK);
    check_val("t2_data", {24'd0, rx_data}, 32'hA5);
    check_val("t2_busy", {31'd0, busy}, 0);

    // 3: short glitch is rejected
    bit_hold(1'b0, 25);
    check_val("t3_busy_hi", {31'd0, busy}, 1);
    bit_hold(1'b0, 5);
    bit_hold(1'b1, BIT_CLK);
    check_val("t3_busy_lo", {31'd0, busy}, 0);

    // 4: framing error, held break, then recovery
    send_frame(8'h3C, 1'b0);
    bit_hold(1'b0, 3 * BIT_CLK);
    bit_hold(1'b1, 2 * BIT_CLK);
    check_val("t4_hold", {24'd0, rx_data}, 32'hA5);
    send_frame(8'h81, 1'b1);
    bit_hold(1'b1, BIT_CLK);
    check_val("t4_data", {24'd0, rx_data}, 32'h81);

    // 5: back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    bit_hold(1'b1, BIT_CLK);
    check_val("t5_data", {24'd0, rx_data}, 32'hFF);

    // 6: reset during bit 4 of 0x5A aborts the frame silently
    d = 8'h5A;
    bit_hold(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) bit_hold(d[i], BIT_CLK);
    bit_hold(d[4], 80);
    rst_n = 1'b0;
    last_good = 8'h00;
    bit_hold(1'b1, 20);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("t6_data_rst", {24'd0, rx_data}, 0);
    check_val("t6_busy_rst", {31'd0, busy}, 0);
    bit_hold(1'b1, 2 * BIT_CLK);
    send_frame(8'hC3, 1'b1);
    bit_hold(1'b1, BIT_CLK);
    check_val("t6_data", {24'd0, rx_data}, 32'hC3);

    // Randomized frames, some with a low stop bit, random gaps and tick phase
    for (int n = 0; n < 16; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, stop);
      if (stop) bit_hold(1'b1, $urandom_range(0, 100));
      else      bit_hold(1'b1, BIT_CLK + $urandom_range(0, 100));
    end

    bit_hold(1'b1, 2 * BIT_CLK);
    check_val("end_busy", {31'd0, busy}, 0);
    check_val("end_data", {24'd0, rx_data}, {24'd0, last_good});
    check_val("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
